// File: rtl/button_input_port_if.sv
// CPU-side read interface of the button input port.
//   read_req   : one-cycle read strobe from the CPU
//   data_out   : head entry, zero-extended switch value, 0 when nothing is pending
//   data_valid : at least one captured entry is pending
//   overflow   : sticky, a press was dropped because storage was full
// master = CPU datapath, slave = button_input_port.
interface button_input_port_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  read_req;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  overflow;

  modport master (
    output read_req,
    input  data_out,
    input  data_valid,
    input  overflow
  );

  modport slave (
    input  read_req,
    output data_out,
    output data_valid,
    output overflow
  );
endinterface

// File: rtl/button_input_port.sv
// Input-side peripheral for the stack CPU. The raw push button is synchronised and
// debounced; every accepted press captures the synchronised switch value into storage,
// which the CPU drains one entry per read strobe.
//
// Ports:
//   clk      : system clock, all state on posedge
//   rst      : asynchronous active-high reset
//   button   : raw asynchronous push button
//   switches : raw asynchronous switch levels (SW_WIDTH bits)
//   pressed  : debounced button level, for an LED
//   bus      : read interface (slave modport) - read_req, data_out, data_valid, overflow
//
// Build option: define INPUT_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise a
// single holding register (capacity 1) is used and FIFO_DEPTH is only range-checked.
module button_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  input  logic [SW_WIDTH-1:0] switches,
  output logic                pressed,
  button_input_port_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : gen_chk_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (DATA_WIDTH < SW_WIDTH) begin : gen_chk_width
    $error("DATA_WIDTH must be >= SW_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StStableLo = 2'd0;
  localparam logic [1:0] StWaitHi   = 2'd1;
  localparam logic [1:0] StStableHi = 2'd2;
  localparam logic [1:0] StWaitLo   = 2'd3;

  // Two-flop synchronisers.
  logic                btn_meta_q, btn_sync_q;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce FSM. A level change is accepted only after the synced button has held the
  // new level for DEBOUNCE_CYCLES further cycles; any glitch back restarts from stable.
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StStableLo: begin
        if (btn_sync_q) begin
          state_d = StWaitHi;
          cnt_d   = '0;
        end
      end
      StWaitHi: begin
        if (!btn_sync_q) begin
          state_d = StStableLo;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStableHi: begin
        if (!btn_sync_q) begin
          state_d = StWaitLo;
          cnt_d   = '0;
        end
      end
      StWaitLo: begin
        if (btn_sync_q) begin
          state_d = StStableHi;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = (state_q == StStableHi) || (state_q == StWaitLo);

  // Storage. A capture is written when there is room, or when a read in the same cycle
  // frees the slot; otherwise it is dropped and flagged.
  logic                valid;
  logic                do_read;
  logic                do_write;
  logic [SW_WIDTH-1:0] head;

`ifdef INPUT_FIFO_EN
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);

  logic [SW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]     count_q;
  logic                full;

  assign full     = (count_q == OccW'(FIFO_DEPTH));
  assign valid    = (count_q != '0);
  assign do_read  = bus.read_req && valid;
  assign do_write = capture && (!full || do_read);
  assign head     = mem_q[rd_ptr_q];

  // Pointers wrap naturally since FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= sw_sync_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_read) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_write && !do_read) begin
        count_q <= count_q + OccW'(1);
      end else if (do_read && !do_write) begin
        count_q <= count_q - OccW'(1);
      end
    end
  end
`else
  logic [SW_WIDTH-1:0] hold_q;
  logic                hold_valid_q;

  assign valid    = hold_valid_q;
  assign do_read  = bus.read_req && valid;
  assign do_write = capture && (!valid || do_read);
  assign head     = hold_q;

  // Capture + read together replaces the register and keeps it valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (do_write) begin
        hold_q       <= sw_sync_q;
        hold_valid_q <= 1'b1;
      end else if (do_read) begin
        hold_valid_q <= 1'b0;
      end
    end
  end
`endif

  logic overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (capture && !do_write) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.data_valid = valid;
  assign bus.overflow   = overflow_q;

  always_comb begin
    bus.data_out = '0;
    if (valid) begin
      bus.data_out[SW_WIDTH-1:0] = head;
    end
  end

endmodule

// File: tb/tb_button_input_port.sv
module tb_button_input_port;
  localparam int unsigned Deb   = 4;
  localparam int unsigned SwW   = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned Depth = 4;
`ifdef INPUT_FIFO_EN
  localparam int Cap = Depth;
`else
  localparam int Cap = 1;
`endif

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic           button   = 1'b0;
  logic [SwW-1:0] switches = '0;
  logic           pressed;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  button_input_port_if #(.DATA_WIDTH(DW)) bus ();

  button_input_port #(
    .DEBOUNCE_CYCLES(Deb),
    .SW_WIDTH       (SwW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .switches(switches),
    .pressed (pressed),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the synced button is the raw button two edges late; the accepted
  // level flips once the synced level has differed from it on Deb+1 consecutive edges.
  // Storage is a queue of capacity Cap.
  logic           m_b1 = 1'b0, m_b2 = 1'b0, m_lvl = 1'b0, m_ovf = 1'b0, m_cap, m_rd;
  logic [SwW-1:0] m_s1 = '0, m_s2 = '0;
  int             m_run = 0;
  logic [DW-1:0]  m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b1 = 1'b0; m_b2 = 1'b0; m_lvl = 1'b0; m_ovf = 1'b0;
      m_s1 = '0; m_s2 = '0; m_run = 0;
      m_q.delete();
    end else begin
      m_cap = 1'b0;
      if (m_b2 != m_lvl) begin
        m_run++;
        if (m_run == int'(Deb) + 1) begin
          m_lvl = m_b2;
          m_run = 0;
          m_cap = m_b2;
        end
      end else begin
        m_run = 0;
      end
      m_rd = bus.read_req && (m_q.size() > 0);
      if (m_rd) void'(m_q.pop_front());
      if (m_cap) begin
        if (m_q.size() < Cap) m_q.push_back(DW'(m_s2));
        else m_ovf = 1'b1;
      end
      m_b2 = m_b1; m_b1 = button;
      m_s2 = m_s1; m_s1 = switches;
    end
  end

  function automatic logic [DW-1:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("model_data_valid", 32'(bus.data_valid), 32'(m_q.size() > 0));
      check("model_data_out",   32'(bus.data_out),   32'(m_head()));
      check("model_overflow",   32'(bus.overflow),   32'(m_ovf));
      check("model_pressed",    32'(pressed),        32'(m_lvl));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cycles_to_valid(output int n);
    n = 0;
    while (bus.data_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_one();
    bus.read_req = 1'b1;
    tick(1);
    bus.read_req = 1'b0;
  endtask

  task automatic press(input logic [SwW-1:0] v);
    switches = v;
    tick(3);
    button = 1'b1;
    tick(10);
    button = 1'b0;
    tick(10);
  endtask

  int n;

  initial begin
    bus.read_req = 1'b0;
    tick(3);
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_overflow",   32'(bus.overflow),   32'h0);
    check("rst_pressed",    32'(pressed),        32'h0);
    rst = 1'b0;
    tick(2);

    // Basic capture and latency.
    switches = 4'hA;
    tick(3);
    button = 1'b1;
    cycles_to_valid(n);
    check("t1_latency", 32'(n), 32'd7);
    check("t1_data", 32'(bus.data_out), 32'h000A);
    check("t1_pressed", 32'(pressed), 32'h1);
    tick(3);
    button = 1'b0;
    tick(10);
    read_one();
    check("t1_read_valid", 32'(bus.data_valid), 32'h0);
    check("t1_read_data", 32'(bus.data_out), 32'h0);

    // Bounce: 2-cycle toggles never survive debounce.
    switches = 4'h6;
    tick(3);
    for (int k = 0; k < 6; k++) begin
      button = (k % 2 == 0);
      tick(2);
    end
    check("t2_no_press", 32'(pressed), 32'h0);
    check("t2_no_capture", 32'(bus.data_valid), 32'h0);
    button = 1'b1;
    cycles_to_valid(n);
    check("t2_latency", 32'(n), 32'd7);
    check("t2_pressed", 32'(pressed), 32'h1);
    check("t2_data", 32'(bus.data_out), 32'h0006);
    tick(3);
    button = 1'b0;
    tick(10);
    read_one();
    check("t2_single_capture", 32'(bus.data_valid), 32'h0);

    // Empty reads are ignored.
    for (int k = 0; k < 3; k++) begin
      read_one();
      check("t6_empty_valid", 32'(bus.data_valid), 32'h0);
    end
    press(4'hC);
    check("t6_data", 32'(bus.data_out), 32'h000C);
    read_one();
    check("t6_drained", 32'(bus.data_valid), 32'h0);

    // Full storage, capture coinciding with a read.
    for (int i = 0; i < Cap; i++) press(SwW'(7 + i));
    switches = 4'hE;
    tick(3);
    button = 1'b1;
    tick(6);
    bus.read_req = 1'b1;
    tick(1);
    bus.read_req = 1'b0;
    check("t4_overflow", 32'(bus.overflow), 32'h0);
    check("t4_valid", 32'(bus.data_valid), 32'h1);
    check("t4_head", 32'(bus.data_out), (Cap == 1) ? 32'h000E : 32'h0008);
    tick(3);
    button = 1'b0;
    tick(10);
    for (int i = 0; i < Cap; i++) read_one();
    check("t4_drained", 32'(bus.data_valid), 32'h0);

    // Overflow: Cap+1 presses without reads.
    for (int i = 0; i <= Cap; i++) press((Cap == 1) ? ((i == 0) ? 4'h3 : 4'h5) : SwW'(i + 1));
    check("t3_overflow", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < Cap; i++) begin
      check("t3_read", 32'(bus.data_out), (Cap == 1) ? 32'h3 : 32'(i + 1));
      read_one();
    end
    check("t3_drained", 32'(bus.data_valid), 32'h0);
    check("t3_sticky", 32'(bus.overflow), 32'h1);
    press(4'h9);

    // Reset in the middle of the press debounce.
    switches = 4'h5;
    tick(3);
    button = 1'b1;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("t5_async_data_out", 32'(bus.data_out),   32'h0);
    check("t5_async_valid",    32'(bus.data_valid), 32'h0);
    check("t5_async_overflow", 32'(bus.overflow),   32'h0);
    check("t5_async_pressed",  32'(pressed),        32'h0);
    @(negedge clk);
    rst = 1'b0;
    cycles_to_valid(n);
    check("t5_latency", 32'(n), 32'(Deb + 3));
    check("t5_data", 32'(bus.data_out), 32'h0005);
    button = 1'b0;
    tick(10);
    read_one();
    check("t5_drained", 32'(bus.data_valid), 32'h0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
